// File: rtl/bus_decode_pkg.sv
// Shared types and helpers for the 8088 bus decode / wait-state controller.
//   state_e        : controller FSM states
//   WAIT_W         : width of a per-channel wait-state count
//   TIMEOUT_W      : ACTIVE-phase counter width for the default TIMEOUT of 64
//   onehot_to_idx  : index of the set bit in a (<=16 bit) one-hot vector
package bus_decode_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LATCH  = 2'd1,
    WAITS  = 2'd2,
    ACTIVE = 2'd3
  } state_e;

  localparam int WAIT_W      = 4;
  localparam int TIMEOUT_DEF = 64;
  localparam int TIMEOUT_W   = $clog2(TIMEOUT_DEF);

  // OR-reduce the indices of all set bits; exact for a one-hot or zero input.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++)
      if (oh[i]) idx = idx | 4'(i);
    return idx;
  endfunction

endpackage

// File: rtl/bus_decode_ctrl_if.sv
// CPU-side bus bundle for bus_decode_ctrl.
//   master : CPU / testbench side (drives ALE, A, AD, IOM, RD, WR)
//   slave  : controller side (drives Address, CS, READY, BUS_ERR, ERR_ADDR)
interface bus_decode_ctrl_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 20
);
  logic              ALE;
  logic [ADDR_W-9:0] A;
  logic [7:0]        AD;
  logic              IOM;
  logic              RD;
  logic              WR;
  logic [ADDR_W-1:0] Address;
  logic [NUM_CH-1:0] CS;
  logic              READY;
  logic              BUS_ERR;
  logic [ADDR_W-1:0] ERR_ADDR;

  modport master (
    output ALE, A, AD, IOM, RD, WR,
    input  Address, CS, READY, BUS_ERR, ERR_ADDR
  );

  modport slave (
    input  ALE, A, AD, IOM, RD, WR,
    output Address, CS, READY, BUS_ERR, ERR_ADDR
  );
endinterface

// File: rtl/bus_decode_ctrl_chan_match.sv
// Combinational region decoder: compares an address/space pair against every
// channel's base/mask/space and keeps only the lowest-index hit.
//   i_addr   : latched bus address
//   i_iom    : 1 = I/O space, 0 = memory
//   o_hit    : at least one channel matched
//   o_idx    : index of the winning channel (0 when no hit)
//   o_onehot : one-hot of the winning channel (0 when no hit)
module chan_match
  import bus_decode_pkg::*;
#(
  parameter int                       NUM_CH = 4,
  parameter int                       ADDR_W = 20,
  parameter logic [NUM_CH*ADDR_W-1:0] BASE   = '0,
  parameter logic [NUM_CH*ADDR_W-1:0] MASK   = '0,
  parameter logic [NUM_CH-1:0]        IS_IO  = '0,
  localparam int                      IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_iom,
  output logic              o_hit,
  output logic [IDX_W-1:0]  o_idx,
  output logic [NUM_CH-1:0] o_onehot
);

  logic [NUM_CH-1:0] w_raw;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [ADDR_W-1:0] M = MASK[g*ADDR_W +: ADDR_W];
    localparam logic [ADDR_W-1:0] B = BASE[g*ADDR_W +: ADDR_W] & M;
    assign w_raw[g] = ((i_addr & M) == B) && (i_iom == IS_IO[g]);
  end

  // x & -x isolates the lowest set bit: lowest channel index wins.
  assign o_onehot = w_raw & (~w_raw + NUM_CH'(1));
  assign o_hit    = |w_raw;
  assign o_idx    = IDX_W'(onehot_to_idx(16'(o_onehot)));

endmodule

// File: rtl/bus_decode_ctrl.sv
// Clocked address latch, chip-select decoder and wait-state generator for the
// 8088 minimum-mode bus.
//   CLK, RESET : bus clock, synchronous active-low reset
//   bus.slave  : ALE/A/AD/IOM/RD/WR in; Address, one-hot CS, READY,
//                BUS_ERR (1-cycle pulse on miss or timeout), ERR_ADDR out
// Region tables are packed with channel 0 in the LSBs. Defaults:
//   ch0 mem 00000/80000 wait 0   ch1 mem 80000/80000 wait 2
//   ch2 io  0FF00/0FFF0 wait 1   ch3 io  01C00/0FE00 wait 3
module bus_decode_ctrl
  import bus_decode_pkg::*;
#(
  parameter int                       NUM_CH  = 4,
  parameter int                       ADDR_W  = 20,
  parameter logic [NUM_CH*ADDR_W-1:0] BASE    = {20'h01C00, 20'h0FF00, 20'h80000, 20'h00000},
  parameter logic [NUM_CH*ADDR_W-1:0] MASK    = {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000},
  parameter logic [NUM_CH-1:0]        IS_IO   = 4'b1100,
  parameter logic [NUM_CH*4-1:0]      WAIT    = {4'd3, 4'd1, 4'd2, 4'd0},
  parameter int                       TIMEOUT = 64
) (
  input  logic            CLK,
  input  logic            RESET,
  bus_decode_ctrl_if.slave bus
);

  localparam int TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_err_addr;
  logic [NUM_CH-1:0] r_cs;
  logic              r_ready;
  logic              r_bus_err;
  logic [WAIT_W-1:0] r_cnt;
  logic [TW-1:0]     r_tcnt;
  logic              r_strobe;

  logic              w_hit;
  logic [IDX_W-1:0]  w_idx;
  logic [NUM_CH-1:0] w_oh;
  logic [WAIT_W-1:0] w_wait;
  logic [WAIT_W-1:0] w_wait_tab [NUM_CH];
  logic              w_strobe;
  logic              w_done;

  // Decode uses the registered address and the live IOM; IOM only matters on
  // the LATCH->decode edge.
  chan_match #(
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W),
    .BASE   (BASE),
    .MASK   (MASK),
    .IS_IO  (IS_IO)
  ) u_match (
    .i_addr   (r_addr),
    .i_iom    (bus.IOM),
    .o_hit    (w_hit),
    .o_idx    (w_idx),
    .o_onehot (w_oh)
  );

  for (genvar g = 0; g < NUM_CH; g++) begin : g_wait
    assign w_wait_tab[g] = WAIT[g*WAIT_W +: WAIT_W];
  end
  assign w_wait = w_wait_tab[w_idx];

  // RD and WR low together simply count as a strobe.
  assign w_strobe = ~bus.RD | ~bus.WR;
  assign w_done   = bus.RD & bus.WR & r_strobe;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_err_addr <= '0;
      r_cs       <= '0;
      r_ready    <= 1'b1;
      r_bus_err  <= 1'b0;
      r_cnt      <= '0;
      r_tcnt     <= '0;
      r_strobe   <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      // ALE restarts from any state: in IDLE/LATCH it latches, elsewhere it
      // silently aborts the running cycle.
      if (bus.ALE) begin
        r_addr  <= {bus.A, bus.AD};
        r_cs    <= '0;
        r_ready <= 1'b1;
        r_state <= LATCH;
      end else begin
        unique case (r_state)
          IDLE: ;
          LATCH: begin
            if (w_hit) begin
              r_cs     <= w_oh;
              r_cnt    <= w_wait;
              r_tcnt   <= '0;
              r_strobe <= 1'b0;
              if (w_wait == '0) begin
                r_ready <= 1'b1;
                r_state <= ACTIVE;
              end else begin
                r_ready <= 1'b0;
                r_state <= WAITS;
              end
            end else begin
              r_bus_err  <= 1'b1;
              r_err_addr <= r_addr;
              r_cs       <= '0;
              r_ready    <= 1'b1;
              r_state    <= IDLE;
            end
          end
          WAITS: begin
            r_cnt <= r_cnt - WAIT_W'(1);
            // Leaving on cnt==1 keeps READY low for exactly WAIT cycles.
            if (r_cnt == WAIT_W'(1)) begin
              r_ready  <= 1'b1;
              r_tcnt   <= '0;
              r_strobe <= 1'b0;
              r_state  <= ACTIVE;
            end
          end
          ACTIVE: begin
            if (w_done) begin
              r_cs    <= '0;
              r_state <= IDLE;
            end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
              r_bus_err  <= 1'b1;
              r_err_addr <= r_addr;
              r_cs       <= '0;
              r_state    <= IDLE;
            end else begin
              r_tcnt <= r_tcnt + TW'(1);
              if (w_strobe) r_strobe <= 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.Address  = r_addr;
  assign bus.CS       = r_cs;
  assign bus.READY    = r_ready;
  assign bus.BUS_ERR  = r_bus_err;
  assign bus.ERR_ADDR = r_err_addr;

endmodule

// File: tb/tb_bus_decode_ctrl.sv
// Self-checking bench for bus_decode_ctrl: transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, then
// randomized transactions with aborts, timeouts and resets.
module tb_bus_decode_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_decode_ctrl_if #(.NUM_CH(4), .ADDR_W(20)) bus ();

  bus_decode_ctrl #(.NUM_CH(4), .ADDR_W(20), .TIMEOUT(64)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Region table: index = channel number.
  logic [19:0] T_BASE [4] = '{20'h00000, 20'h80000, 20'h0FF00, 20'h01C00};
  logic [19:0] T_MASK [4] = '{20'h80000, 20'h80000, 20'h0FFF0, 20'h0FE00};
  bit          T_IO   [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  int          T_WAIT [4] = '{0, 2, 1, 3};
  localparam int TMO = 64;

  function automatic int region_of(input logic [19:0] a, input bit iom);
    for (int c = 0; c < 4; c++)
      if (((a & T_MASK[c]) == (T_BASE[c] & T_MASK[c])) && (iom == T_IO[c])) return c;
    return -1;
  endfunction

  // Reference model: phase 0 idle, 1 address latched, 2 counting waits,
  // 3 data phase. Expected outputs are what the DUT shows after each edge.
  int          m_phase = 0;
  logic [19:0] m_addr = '0, m_eaddr = '0;
  logic [3:0]  m_cs = '0;
  bit          m_ready = 1'b1, m_err = 1'b0, m_strobe = 1'b0;
  int          m_left = 0, m_act = 0;
  int          cyc = 0;

  always @(posedge clk) begin
    int ch;
    cyc++;
    if (!rst_n) begin
      m_phase = 0; m_addr = '0; m_eaddr = '0; m_cs = '0;
      m_ready = 1'b1; m_err = 1'b0; m_left = 0; m_act = 0; m_strobe = 1'b0;
    end else begin
      m_err = 1'b0;
      if (bus.ALE) begin
        m_addr = {bus.A, bus.AD}; m_cs = '0; m_ready = 1'b1; m_phase = 1;
      end else if (m_phase == 1) begin
        ch = region_of(m_addr, bus.IOM);
        if (ch < 0) begin
          m_err = 1'b1; m_eaddr = m_addr; m_phase = 0;
        end else begin
          m_cs = 4'(1 << ch);
          m_act = 0; m_strobe = 1'b0;
          if (T_WAIT[ch] == 0) m_phase = 3;
          else begin m_ready = 1'b0; m_left = T_WAIT[ch]; m_phase = 2; end
        end
      end else if (m_phase == 2) begin
        m_left--;
        if (m_left == 0) begin m_ready = 1'b1; m_phase = 3; end
      end else if (m_phase == 3) begin
        if (m_strobe && bus.RD && bus.WR) begin
          m_cs = '0; m_phase = 0;
        end else if (m_act == TMO - 1) begin
          m_err = 1'b1; m_eaddr = m_addr; m_cs = '0; m_phase = 0;
        end else begin
          m_act++;
          if (!bus.RD || !bus.WR) m_strobe = 1'b1;
        end
      end
    end
  end

  // Per-cycle compare plus observation counters used by directed checks.
  int obs_rdy_low = 0, obs_err = 0, obs_err_cyc = 0;
  always @(negedge clk) begin
    chk("addr",     bus.Address,  m_addr);
    chk("cs",       bus.CS,       m_cs);
    chk("ready",    bus.READY,    m_ready);
    chk("bus_err",  bus.BUS_ERR,  m_err);
    chk("err_addr", bus.ERR_ADDR, m_eaddr);
    if (!bus.READY) obs_rdy_low++;
    if (bus.BUS_ERR) begin obs_err++; obs_err_cyc = cyc; end
  end

  logic [3:0]  s_first_cs, s_hold_cs, s_after_cs;
  logic        s_first_rdy;
  logic [19:0] s_first_addr;
  int          s_dec_cyc;

  // One bus cycle: ALE for one clock, strobe low for slen clocks starting
  // with ALE's fall, then post idle clocks.
  task automatic run_cycle(input logic [19:0] addr, input bit iom, input bit wr,
                           input int slen, input int post);
    @(negedge clk);
    bus.ALE = 1'b1; bus.A = addr[19:8]; bus.AD = addr[7:0]; bus.IOM = iom;
    @(negedge clk);
    bus.ALE = 1'b0; bus.AD = 8'($urandom);
    if (slen > 0) begin
      if (wr) bus.WR = 1'b0; else bus.RD = 1'b0;
    end
    @(negedge clk);
    s_first_cs = bus.CS; s_first_rdy = bus.READY; s_first_addr = bus.Address;
    s_dec_cyc = cyc;
    if (slen > 0) begin
      repeat (slen - 1) @(negedge clk);
      s_hold_cs = bus.CS;
      bus.RD = 1'b1; bus.WR = 1'b1;
    end
    @(negedge clk);
    s_after_cs = bus.CS;
    repeat (post) @(negedge clk);
  endtask

  task automatic clr_obs();
    @(negedge clk);
    obs_rdy_low = 0; obs_err = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.ALE = 1'b0; bus.A = '0; bus.AD = '0; bus.IOM = 1'b0; bus.RD = 1'b1; bus.WR = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.READY, 1'b1);
    chk("rst_cs",    bus.CS,    4'b0000);
    chk("rst_addr",  bus.Address, 20'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Memory read, ch0, no waits.
    clr_obs();
    run_cycle(20'h00100, 1'b0, 1'b0, 3, 2);
    chk("mrd_addr",  s_first_addr, 20'h00100);
    chk("mrd_cs",    s_first_cs,   4'b0001);
    chk("mrd_rdy",   s_first_rdy,  1'b1);
    chk("mrd_rdylo", obs_rdy_low,  0);
    chk("mrd_clear", s_after_cs,   4'b0000);

    // Memory write, ch1, 2 waits.
    clr_obs();
    run_cycle(20'h80010, 1'b0, 1'b1, 5, 2);
    chk("mwr_cs",    s_first_cs,  4'b0010);
    chk("mwr_rdylo", obs_rdy_low, 2);
    chk("mwr_hold",  s_hold_cs,   4'b0010);
    chk("mwr_clear", s_after_cs,  4'b0000);

    // I/O read ch3 (3 waits), then same address as memory -> ch0.
    clr_obs();
    run_cycle(20'h01C05, 1'b1, 1'b0, 6, 2);
    chk("iord_cs",    s_first_cs,  4'b1000);
    chk("iord_rdylo", obs_rdy_low, 3);
    chk("iord_clear", s_after_cs,  4'b0000);
    clr_obs();
    run_cycle(20'h01C05, 1'b0, 1'b0, 3, 2);
    chk("iomem_cs",    s_first_cs,  4'b0001);
    chk("iomem_rdylo", obs_rdy_low, 0);

    // Unmapped I/O.
    clr_obs();
    run_cycle(20'h02000, 1'b1, 1'b0, 0, 2);
    chk("unm_cs",   s_first_cs,   4'b0000);
    chk("unm_rdy",  s_first_rdy,  1'b1);
    chk("unm_errs", obs_err,      1);
    chk("unm_eadr", bus.ERR_ADDR, 20'h02000);

    // No strobe on ch1: timeout 64 ACTIVE cycles after 2 wait cycles.
    clr_obs();
    run_cycle(20'h80000, 1'b0, 1'b0, 0, 70);
    chk("tmo_errs", obs_err, 1);
    chk("tmo_when", obs_err_cyc - s_dec_cyc, 66);
    chk("tmo_eadr", bus.ERR_ADDR, 20'h80000);
    chk("tmo_cs",   bus.CS, 4'b0000);

    // Reset during WAITS on ch3.
    @(negedge clk);
    bus.ALE = 1'b1; bus.A = 12'h01C; bus.AD = 8'h05; bus.IOM = 1'b1;
    @(negedge clk);
    bus.ALE = 1'b0; bus.RD = 1'b0;
    @(negedge clk);
    chk("rw_inwait", bus.READY, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; bus.RD = 1'b1;
    chk("rw_ready", bus.READY, 1'b1);
    chk("rw_cs",    bus.CS, 4'b0000);
    chk("rw_addr",  bus.Address, 20'h0);
    run_cycle(20'h80010, 1'b0, 1'b1, 5, 2);
    chk("rw_after_cs", s_first_cs, 4'b0010);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int t = 0; t < 400; t++) begin
      logic [19:0] a;
      int sel, slen, post;
      sel = $urandom_range(0, 5);
      case (sel)
        0: a = 20'($urandom);
        1: a = {1'b0, 19'($urandom)};
        2: a = {1'b1, 19'($urandom)};
        3: a = {16'h0FF0, 4'($urandom)};
        4: a = {11'h00E, 9'($urandom)};
        default: a = 20'h02000;
      endcase
      slen = $urandom_range(0, 8);
      post = ($urandom_range(0, 24) == 0) ? 70 : $urandom_range(0, 3);
      run_cycle(a, 1'($urandom), 1'($urandom), slen, post);
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_decode_ctrl.md
Name: bus_decode_ctrl

Overview:
Parametrised address-latch, chip-select and wait-state controller for the 8088 minimum-mode bus. It replaces the ad-hoc ALE latch and combinational CS decode in the top level with one clocked block. The block serves NUM_CH memory or I/O regions, each with its own base, mask, space and wait-state count. It drives the one-hot CS vector, the CPU READY line, and reports bus errors for unmapped or stalled cycles.

Parameters:
NUM_CH, 4, number of decoded regions (1..16)
ADDR_W, 20, bus address width
BASE, {20'h00000,20'h80000,20'h0FF00,20'h01C00}, packed NUM_CH*ADDR_W region base addresses; channel 0 is in the LSBs
MASK, {20'h80000,20'h80000,20'h0FFF0,20'h0FE00}, packed NUM_CH*ADDR_W compare masks
IS_IO, 4'b1100, per-channel space select; 1 = I/O (IOM=1), 0 = memory
WAIT, {4'd0,4'd2,4'd1,4'd3}, packed NUM_CH*4 READY-low cycles per channel
TIMEOUT, 64, maximum cycles in ACTIVE without strobe completion

Ports:
CLK  in  1  bus clock
RESET  in  1  synchronous, active-low reset
ALE  in  1  address latch enable from CPU
A  in  ADDR_W-8  upper address from CPU
AD  in  8  multiplexed low address/data, sampled only while ALE=1
IOM  in  1  1 = I/O cycle, 0 = memory cycle
RD  in  1  active-low read strobe
WR  in  1  active-low write strobe
Address  out  ADDR_W  registered latched bus address
CS  out  NUM_CH  registered one-hot chip selects
READY  out  1  registered CPU READY
BUS_ERR  out  1  one-cycle pulse on unmapped access or timeout
ERR_ADDR  out  ADDR_W  Address captured at the last BUS_ERR

Behaviour:
- Reset (RESET=0 at posedge CLK): state=IDLE, Address=0, CS=0, READY=1, BUS_ERR=0, ERR_ADDR=0, counters=0.
- Match rule for channel i: ((Address & MASK[i]) == (BASE[i] & MASK[i])) && (IOM == IS_IO[i]). If several channels match, the lowest index wins.
- IDLE: READY=1, CS=0. ALE=1 -> Address <= {A,AD}; go LATCH.
- LATCH: Address reloads every cycle while ALE=1. On the first cycle with ALE=0, decode Address:
  - hit with WAIT=0 -> CS[i]=1, READY=1, go ACTIVE.
  - hit with WAIT=n>0 -> CS[i]=1, READY=0, cnt=n, go WAITS.
  - miss -> BUS_ERR=1 for 1 cycle, ERR_ADDR<=Address, READY=1, CS=0, go IDLE.
- WAITS: READY=0 and cnt decrements each cycle. When cnt==1, READY=1 next cycle and go ACTIVE. READY is low for exactly n cycles, starting the cycle after ALE falls.
- ACTIVE: CS held. A strobe_seen flag sets on RD=0 or WR=0. Exit to IDLE (CS=0) on the first cycle with RD=1, WR=1 and strobe_seen=1.
  - tcnt counts cycles in ACTIVE. At tcnt==TIMEOUT-1 with no exit: BUS_ERR pulse, ERR_ADDR<=Address, CS=0, go IDLE.
- ALE=1 in any non-IDLE state aborts the current cycle: CS=0, READY=1, Address reloads, go LATCH. No BUS_ERR is raised.
- RD=0 and WR=0 together are treated as a strobe; no special handling.
- IOM is sampled at decode only; later changes are ignored until the next cycle.
- An ADDR_W mismatch with the CPU is not handled: top level ties unused A bits to 0.
- Reset mid-cycle overrides all transitions.

Decomposition:
- Package bus_decode_pkg holds:
  - state enum (IDLE, LATCH, WAITS, ACTIVE)
  - WAIT_W=4
  - TIMEOUT_W = $clog2(TIMEOUT)
  - function onehot_to_idx
- Sub-module chan_match: combinational per-channel compare plus lowest-index priority. Outputs hit, idx and one-hot vector.

Test Plan:
- Memory read at 20'h00100 (IOM=0): ALE 1 cycle, RD low 3 cycles -> CS=4'b0001 the cycle after ALE falls, READY stays 1, CS clears the cycle after RD rises.
- Memory write at 20'h80010 -> CS=4'b0010, READY=0 for exactly 2 cycles then 1, CS held until WR returns high.
- I/O read at 16'h1C05 (IOM=1) -> CS=4'b1000, READY low 3 cycles. Same address with IOM=0 -> CS=4'b0001 (memory ch0), READY never low.
- Unmapped I/O at 16'h2000 -> BUS_ERR=1 for one cycle, ERR_ADDR=20'h02000, CS=0, READY=1.
- Hit on ch1 with no RD/WR strobe for 64 cycles -> BUS_ERR pulse at ACTIVE cycle 64, CS returns to 0.
- RESET=0 asserted during WAITS on ch3 -> next cycle READY=1, CS=0, Address=0; a new ALE cycle then decodes normally.
